if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline: the producer side of the IF/ID pipeline register. It owns the fetch PC, drives the instruction SRAM port (synchronous, 1-cycle read latency) and presents {instruction, PC, PC+4, address-fault} to IF/ID each cycle. It honours the same `stall` that freezes IF/ID, redirects on taken branches and exception flushes, and flags misaligned fetches instead of issuing them.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset
- `EXC_VECTOR`, 32'hBFC0_0380, fetch address after `exc_flush`
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  pipeline stall (same signal as IF/ID stall)
- `branch_taken`  in  1  taken branch/jump resolved in ID this cycle
- `branch_target`  in  32  redirect address
- `exc_flush`  in  1  exception redirect from the exception unit
- `inst_sram_en`  out  1  SRAM read enable
- `inst_sram_addr`  out  32  word address, `{fetch_addr[31:2],2'b00}`
- `inst_sram_rdata`  in  32  read data, valid the cycle after `en`
- `inst_o`  out  32  instruction to IF/ID
- `pc_o`  out  32  PC of `inst_o`
- `pc4_o`  out  32  `pc_o + 4`
- `addr_fault_o`  out  1  fetch address was misaligned

## Operation
- State: `pc_r` (next sequential address), response stage `resp_valid`, `resp_pc`, `resp_pc4`, `resp_fault`, hold buffer `hold_buf`/`hold_valid`.
- `fetch_addr` = `branch_taken ? branch_target : pc_r`. Combinational, so a taken branch costs no bubble. The delay slot is already in the response stage and is kept.
- Issue when `!stall && !exc_flush`:
  - `fault = |fetch_addr[1:0]`.
  - `inst_sram_en = !fault`.
  - `pc_r <= fetch_addr + 4`.
  - `resp_valid <= 1`, `resp_pc <= fetch_addr`, `resp_pc4 <= fetch_addr + 4`, `resp_fault <= fault`.
- `stall`:
  - No issue, `inst_sram_en = 0`. `pc_r` and the response stage hold.
  - `branch_taken` is ignored; ID re-asserts it after the stall.
- Hold buffer:
  - On the first stall cycle with `resp_valid && !resp_fault && !hold_valid`: `hold_buf <= inst_sram_rdata`, `hold_valid <= 1`.
  - `hold_valid` clears on the first non-stall cycle.
- `exc_flush` has highest priority and overrides `stall`:
  - `inst_sram_en = 0`, `pc_r <= EXC_VECTOR`, `resp_valid <= 0`, `hold_valid <= 0`.
  - The vector is issued on the next non-stall cycle.
- Outputs:
  - `inst_o` = 0 (NOP) if `!resp_valid || resp_fault`; else `hold_valid ? hold_buf : inst_sram_rdata`.
  - `pc_o = resp_pc`, `pc4_o = resp_pc4`, `addr_fault_o = resp_fault & resp_valid`.
- Arithmetic: all PC adds are 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset: `pc_r = RESET_PC`; `resp_valid`, `resp_fault`, `hold_valid` = 0; `resp_pc`, `resp_pc4`, `hold_buf` = 0.
  - Outputs during and after reset: `inst_o = 0`, `pc_o = 0`, `pc4_o = 0`, `addr_fault_o = 0`, `inst_sram_en = 0` while `rst`.
- Reset wins over `stall`, `exc_flush` and `branch_taken`. Reset mid-stall discards the hold buffer.
- Latency: an address issued in cycle t appears on the outputs in cycle t+1, combinationally from `inst_sram_rdata`. Throughput is one instruction per cycle.
- Stall of N cycles: outputs stay constant for all N cycles, using `hold_buf` from the second stall cycle on. Issue resumes in the first cycle with `stall = 0`.
- `branch_taken` together with a misaligned target: `inst_sram_en = 0`. The next cycle shows `pc_o` = target, `addr_fault_o = 1`, `inst_o = 0`.
- `exc_flush` together with `branch_taken`: the flush wins and the branch is dropped. The next cycle is a bubble, and `EXC_VECTOR` is issued in that bubble cycle.

## Structure
- Shared `mips_pkg`: `RESET_PC`, `EXC_VECTOR`, `NOP_INST` (32'h0). This block and the decode stage use the same definitions.
- One natural sub-module: `if_hold_buf`, the 32-bit data-capture/replay register with its valid flag. Everything else stays flat in `if_fetch`.

## Test plan
- Reset then free-run, no stall: the cycle after `rst` drops, `inst_sram_addr` = BFC0_0000. The following cycles show `pc_o` = BFC0_0000, BFC0_0004, … with `pc4_o` = `pc_o + 4` and `inst_o` equal to the SRAM model's words.
- Taken branch at `pc_r` = BFC0_0010 to 8000_0100: that cycle `inst_sram_addr` = 8000_0100. Next cycle `pc_o` = 8000_0100; the delay slot BFC0_000C was output the cycle before; no bubble.
- 3-cycle stall while `pc_o` = BFC0_0008, with the SRAM model driving garbage when `en = 0`: `inst_o` and `pc_o` stay constant for 3 cycles, then BFC0_000C follows.
- `branch_target` = 8000_0102: `inst_sram_en = 0`. Next cycle `addr_fault_o = 1`, `pc_o` = 8000_0102, `inst_o = 0`.
- `exc_flush` during a stall: next cycle `inst_o = 0`, `resp_valid = 0`. After the stall drops, `inst_sram_addr` = BFC0_0380.
- `rst` asserted mid-stall with `hold_valid = 1`: the next cycle shows all outputs 0. After release the fetch restarts at BFC0_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Definitions shared by the MIPS fetch and decode stages.
// Reset/exception vectors, the NOP encoding and the IF response record.
package mips_pkg;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_resp_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Capture/replay register for a fetched word that must outlive its SRAM read cycle.
// Clear takes priority over capture; a captured word is held until cleared.
module if_hold_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= NOP_INST;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            dout  <= din;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction SRAM and
// presents {instruction, PC, PC+4, fault} to the IF/ID register.
module if_fetch
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_flush,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        addr_fault_o
);

    logic [31:0] pc_r;
    logic [31:0] fetch_addr;
    logic [31:0] next_seq;
    logic        fault;
    logic        issue;
    if_resp_t    resp_r;

    logic        hold_valid;
    logic        hold_capture;
    logic        hold_clear;
    logic [31:0] hold_data;

    // Branch redirect is combinational so the target issues in the same cycle.
    always_comb begin
        fetch_addr     = branch_taken ? branch_target : pc_r;
        next_seq       = fetch_addr + 32'd4;
        fault          = is_misaligned(fetch_addr);
        issue          = !rst && !stall && !exc_flush;
        inst_sram_en   = issue && !fault;
        inst_sram_addr = {fetch_addr[31:2], 2'b00};
        hold_clear     = exc_flush || !stall;
        hold_capture   = stall && resp_r.valid && !resp_r.fault && !hold_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r   <= RESET_PC;
            resp_r <= '0;
        end else if (exc_flush) begin
            pc_r         <= EXC_VECTOR;
            resp_r.valid <= 1'b0;
        end else if (!stall) begin
            pc_r         <= next_seq;
            resp_r.valid <= 1'b1;
            resp_r.fault <= fault;
            resp_r.pc    <= fetch_addr;
            resp_r.pc4   <= next_seq;
        end
    end

    // SRAM data is only valid for one cycle after a read; keep it across stalls.
    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .capture (hold_capture),
        .clear   (hold_clear),
        .din     (inst_sram_rdata),
        .dout    (hold_data),
        .valid   (hold_valid)
    );

    always_comb begin
        if (!resp_r.valid || resp_r.fault)
            inst_o = NOP_INST;
        else
            inst_o = hold_valid ? hold_data : inst_sram_rdata;
        pc_o         = resp_r.pc;
        pc4_o        = resp_r.pc4;
        addr_fault_o = resp_r.fault & resp_r.valid;
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a table of per-cycle stimulus with same-cycle SRAM-port
// expectations; next-cycle output expectations go through a scoreboard queue.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, exc_flush;
    logic [31:0] branch_target;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic [31:0] inst_o, pc_o, pc4_o;
    logic        addr_fault_o;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .exc_flush       (exc_flush),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .pc4_o           (pc4_o),
        .addr_fault_o    (addr_fault_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous SRAM model: garbage whenever the previous cycle did not read.
    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : $urandom();

    localparam logic [1:0] K_ZERO = 2'd0, K_INST = 2'd1, K_FAULT = 2'd2, K_BUB = 2'd3;

    typedef struct {
        logic        rst, stall, bt;
        logic [31:0] tgt;
        logic        exc;
        logic        en;
        logic [31:0] addr;
        logic [1:0]  kind;
        logic [31:0] npc;
    } vec_t;

    typedef struct {
        logic [31:0] inst, pc, pc4;
        logic        fault;
    } exp_t;

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @step %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic vec_t row(input logic r, input logic s, input logic bt,
                                 input logic [31:0] tgt, input logic exc, input logic en,
                                 input logic [31:0] addr, input logic [1:0] kind,
                                 input logic [31:0] npc);
        vec_t v;
        v.rst = r; v.stall = s; v.bt = bt; v.tgt = tgt; v.exc = exc;
        v.en = en; v.addr = addr; v.kind = kind; v.npc = npc;
        return v;
    endfunction

    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
        e.inst = 32'h0; e.pc = v.npc; e.pc4 = v.npc + 32'd4; e.fault = 1'b0;
        case (v.kind)
            K_ZERO:  begin e.pc = 32'h0; e.pc4 = 32'h0; end
            K_INST:  e.inst = mem_word(v.npc);
            K_FAULT: e.fault = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; stall = v.stall; branch_taken = v.bt;
        branch_target = v.tgt; exc_flush = v.exc;
        #1;
        chk("sram_en", {31'b0, inst_sram_en}, {31'b0, v.en});
        if (v.en) chk("sram_addr", inst_sram_addr, v.addr);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("inst_o", inst_o, e.inst);
            chk("pc_o", pc_o, e.pc);
            chk("pc4_o", pc4_o, e.pc4);
            chk("addr_fault_o", {31'b0, addr_fault_o}, {31'b0, e.fault});
        end
        sb.push_back(expect_of(v));
        cyc++;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; exc_flush = 1'b0;
        branch_target = 32'h0;

        //                 rst stall bt  target        exc en  addr          next-cycle kind/pc
        tbl.push_back(row(1, 0, 0, 32'h0,          0, 0, 32'h0,          K_ZERO,  32'h0));
        tbl.push_back(row(1, 0, 0, 32'h0,          0, 0, 32'h0,          K_ZERO,  32'h0));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0000, K_INST,  32'hBFC0_0000));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0004, K_INST,  32'hBFC0_0004));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0008, K_INST,  32'hBFC0_0008));
        tbl.push_back(row(0, 1, 0, 32'h0,          0, 0, 32'h0,          K_INST,  32'hBFC0_0008));
        tbl.push_back(row(0, 1, 1, 32'h8000_0400, 0, 0, 32'h0,          K_INST,  32'hBFC0_0008));
        tbl.push_back(row(0, 1, 0, 32'h0,          0, 0, 32'h0,          K_INST,  32'hBFC0_0008));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_000C, K_INST,  32'hBFC0_000C));
        tbl.push_back(row(0, 0, 1, 32'h8000_0100, 0, 1, 32'h8000_0100, K_INST,  32'h8000_0100));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'h8000_0104, K_INST,  32'h8000_0104));
        tbl.push_back(row(0, 0, 1, 32'h8000_0102, 0, 0, 32'h0,          K_FAULT, 32'h8000_0102));
        tbl.push_back(row(0, 0, 1, 32'hBFC0_0100, 0, 1, 32'hBFC0_0100, K_INST,  32'hBFC0_0100));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0104, K_INST,  32'hBFC0_0104));
        tbl.push_back(row(0, 1, 0, 32'h0,          1, 0, 32'h0,          K_BUB,   32'hBFC0_0104));
        tbl.push_back(row(0, 1, 0, 32'h0,          0, 0, 32'h0,          K_BUB,   32'hBFC0_0104));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0380, K_INST,  32'hBFC0_0380));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0384, K_INST,  32'hBFC0_0384));
        tbl.push_back(row(0, 0, 1, 32'h8000_0200, 1, 0, 32'h0,          K_BUB,   32'hBFC0_0384));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0380, K_INST,  32'hBFC0_0380));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0384, K_INST,  32'hBFC0_0384));
        tbl.push_back(row(0, 1, 0, 32'h0,          0, 0, 32'h0,          K_INST,  32'hBFC0_0384));
        tbl.push_back(row(0, 1, 0, 32'h0,          0, 0, 32'h0,          K_INST,  32'hBFC0_0384));
        tbl.push_back(row(1, 1, 0, 32'h0,          0, 0, 32'h0,          K_ZERO,  32'h0));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'hBFC0_0000, K_INST,  32'hBFC0_0000));
        tbl.push_back(row(0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, K_INST,  32'hFFFF_FFFC));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'h0000_0000, K_INST,  32'h0000_0000));
        tbl.push_back(row(0, 0, 0, 32'h0,          0, 1, 32'h0000_0004, K_INST,  32'h0000_0004));

        foreach (tbl[i]) step(tbl[i]);

        // Longer stall: word 0x4 must be replayed from the hold buffer throughout.
        for (int i = 0; i < 5; i++)
            step(row(0, 1, 0, 32'h0, 0, 0, 32'h0, K_INST, 32'h0000_0004));
        step(row(0, 0, 0, 32'h0, 0, 1, 32'h0000_0008, K_INST, 32'h0000_0008));
        step(row(0, 1, 0, 32'h0, 0, 0, 32'h0, K_INST, 32'h0000_0008));

        // The wrapped PC+4 at 0xFFFF_FFFC must read back as zero.
        chk("wrap_pc4", 32'hFFFF_FFFC + 32'd4, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
